// File: rtl/zx_spi_responder.sv
// zx_spi_responder
//   SPI mode-0 target for the SD-card link. The SPI pins are oversampled in
//   the clk28 domain. MOSI bytes are deserialised onto rx_data/rx_valid.
//   MISO bytes are serialised from a one-deep transmit buffer (tx_data/tx_load).
//
// Optional feature (compile-time macro ZX_SPI_RESPONDER_ECHO_EN):
//   When defined, an empty buffer at a byte boundary sends the last received
//   byte (rx_data) instead of FILL_BYTE. The first byte of a frame always
//   uses FILL_BYTE when the buffer is empty.
//
// Ports:
//   clk28      in   system clock (28 MHz)
//   rst_n      in   asynchronous active-low reset
//   sd_sck     in   SPI clock from initiator, idle low
//   sd_ncs     in   chip select, active low
//   sd_mosi    in   initiator-to-responder data
//   sd_miso    out  responder-to-initiator data (1 while deselected)
//   rx_data    out  last complete received byte
//   rx_valid   out  one-cycle strobe when rx_data updates
//   tx_data    in   byte to transmit
//   tx_load    in   write strobe for tx_data
//   tx_ready   out  transmit buffer empty
//   tx_overrun out  sticky: tx_load while the buffer was full
//   busy       out  synchronised chip select asserted
//
// Parameters:
//   FILL_BYTE    byte sent when no transmit byte is pending
//   SYNC_STAGES  synchroniser depth on the SPI inputs (>= 2)
//
// sd_sck must be at most clk28/8 so every pin edge is seen as a distinct
// synchronised edge with settle time before the opposite edge.

module zx_spi_responder #(
  parameter logic [7:0] FILL_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       sd_sck,
  input  logic       sd_ncs,
  input  logic       sd_mosi,
  output logic       sd_miso,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       tx_overrun,
  output logic       busy
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Synchronisers. The chip select chain resets to the deselected level so
  // that reset release never looks like a select edge.
  logic [SYNC_STAGES-1:0] sck_sync_reg;
  logic [SYNC_STAGES-1:0] ncs_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic                   sck_prev_reg;
  logic                   ncs_prev_reg;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_reg  <= '0;
      ncs_sync_reg  <= '1;
      mosi_sync_reg <= '0;
      sck_prev_reg  <= 1'b0;
      ncs_prev_reg  <= 1'b1;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], sd_sck};
      ncs_sync_reg  <= {ncs_sync_reg[SYNC_STAGES-2:0], sd_ncs};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], sd_mosi};
      sck_prev_reg  <= sck_sync_reg[SYNC_STAGES-1];
      ncs_prev_reg  <= ncs_sync_reg[SYNC_STAGES-1];
    end
  end

  logic sck_s, ncs_s, mosi_s;
  logic sck_rise, sck_fall, ncs_rise, ncs_fall;

  assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
  assign ncs_s    = ncs_sync_reg[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_reg[SYNC_STAGES-1];
  assign sck_rise =  sck_s & ~sck_prev_reg;
  assign sck_fall = ~sck_s &  sck_prev_reg;
  assign ncs_rise =  ncs_s & ~ncs_prev_reg;
  assign ncs_fall = ~ncs_s &  ncs_prev_reg;

  state_t      state_reg;
  logic [2:0]  bitcnt_reg;
  logic [7:0]  rx_shift_reg;
  logic [7:0]  tx_shift_reg;
  logic [7:0]  tx_buf_reg;
  logic [7:0]  rx_data_reg;
  logic        rx_valid_reg;
  logic        tx_ready_reg;
  logic        tx_overrun_reg;

  // A chip-select edge masks any sck edge in the same cycle.
  logic ncs_edge;
  logic act_sck_rise, act_sck_fall;
  assign ncs_edge     = ncs_rise | ncs_fall;
  assign act_sck_rise = (state_reg == ST_ACTIVE) && !ncs_edge && sck_rise;
  assign act_sck_fall = (state_reg == ST_ACTIVE) && !ncs_edge && sck_fall;

  // Reload points: frame start, and the falling edge after each full byte.
  logic entry_reload, boundary_reload, reload;
  assign entry_reload    = (state_reg == ST_IDLE) && ncs_fall;
  assign boundary_reload = act_sck_fall && (bitcnt_reg == 3'd0);
  assign reload          = entry_reload | boundary_reload;

  // A reload drains the buffer if it holds a byte.
  logic       consume;
  logic       load_accept;
  logic [7:0] empty_byte;
  logic [7:0] reload_byte;

  assign consume     = reload && !tx_ready_reg;
  // The buffer frees up in the consuming cycle, so a simultaneous load is
  // taken as the next byte rather than flagged as an overrun.
  assign load_accept = tx_load && (tx_ready_reg || consume);

`ifdef ZX_SPI_RESPONDER_ECHO_EN
  assign empty_byte  = boundary_reload ? rx_data_reg : FILL_BYTE;
`else
  assign empty_byte  = FILL_BYTE;
`endif
  assign reload_byte = consume ? tx_buf_reg : empty_byte;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      bitcnt_reg     <= 3'd0;
      rx_shift_reg   <= 8'h00;
      tx_shift_reg   <= 8'h00;
      tx_buf_reg     <= 8'h00;
      rx_data_reg    <= 8'h00;
      rx_valid_reg   <= 1'b0;
      tx_ready_reg   <= 1'b1;
      tx_overrun_reg <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;

      // Transmit buffer
      if (load_accept) begin
        tx_buf_reg   <= tx_data;
        tx_ready_reg <= 1'b0;
      end else if (consume) begin
        tx_ready_reg <= 1'b1;
      end
      if (tx_load && !load_accept) begin
        tx_overrun_reg <= 1'b1;
      end

      if (reload) begin
        tx_shift_reg <= reload_byte;
      end

      case (state_reg)
        ST_IDLE: begin
          bitcnt_reg <= 3'd0;
          if (ncs_fall) begin
            state_reg <= ST_ACTIVE;
          end
        end

        ST_ACTIVE: begin
          if (ncs_rise) begin
            // Partial byte and shifter contents are dropped; the buffer
            // keeps any pending byte for the next frame.
            state_reg  <= ST_IDLE;
            bitcnt_reg <= 3'd0;
          end else if (act_sck_rise) begin
            rx_shift_reg <= {rx_shift_reg[6:0], mosi_s};
            bitcnt_reg   <= bitcnt_reg + 3'd1;
            if (bitcnt_reg == 3'd7) begin
              rx_data_reg  <= {rx_shift_reg[6:0], mosi_s};
              rx_valid_reg <= 1'b1;
            end
          end else if (act_sck_fall && (bitcnt_reg != 3'd0)) begin
            tx_shift_reg <= {tx_shift_reg[6:0], 1'b1};
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign sd_miso    = (state_reg == ST_ACTIVE) ? tx_shift_reg[7] : 1'b1;
  assign busy       = (state_reg == ST_ACTIVE);
  assign rx_data    = rx_data_reg;
  assign rx_valid   = rx_valid_reg;
  assign tx_ready   = tx_ready_reg;
  assign tx_overrun = tx_overrun_reg;

endmodule

// File: doc/zx_spi_responder.md
Name: zx_spi_responder

Overview:
- SPI mode-0 target (responder) for the SD-card link; the ULA's SPI initiator drives it over sd_sck / sd_ncs / sd_mosi / sd_miso.
- Oversamples the SPI pins in the clk28 domain, deserialises MOSI bytes and serialises MISO bytes from a one-deep transmit buffer.
- Used as the synthesizable card-side model in ULA simulations, and as the peripheral-side endpoint when the CPLD is slaved to an external host.

Parameters:
- FILL_BYTE, 8'hFF, byte shifted out when no transmit byte is pending.
- SYNC_STAGES, 2, synchroniser depth on sd_sck, sd_ncs and sd_mosi (minimum 2).

Ports:
- clk28  in  1  system clock, 28 MHz
- rst_n  in  1  asynchronous active-low reset
- sd_sck  in  1  SPI clock from initiator, idle low
- sd_ncs  in  1  chip select, active low
- sd_mosi  in  1  initiator-to-responder data
- sd_miso  out  1  responder-to-initiator data
- rx_data  out  8  last complete received byte
- rx_valid  out  1  one-clk28 strobe when rx_data is updated
- tx_data  in  8  byte to transmit
- tx_load  in  1  write strobe for tx_data
- tx_ready  out  1  transmit buffer empty; tx_load accepted
- tx_overrun  out  1  sticky: tx_load seen while tx_ready=0
- busy  out  1  chip select asserted (synchronised)

Behaviour:
- Reset values: sd_miso=1, rx_data=0, rx_valid=0, tx_ready=1, tx_overrun=0, busy=0. Bit counter, shift registers and synchronisers are cleared.
- sd_sck, sd_ncs and sd_mosi pass through SYNC_STAGES flops; edges are detected against the previous synchronised value.
- Latency: internal action occurs SYNC_STAGES+1 clk28 cycles after a pin edge. Supported sd_sck is at most clk28/8 (3.5 MHz).
- State IDLE (sync ncs=1):
  - sd_miso=1, bitcnt=0.
  - On ncs falling: load tx_shift from the buffer if tx_ready=0 (then tx_ready<=1); otherwise load FILL_BYTE. Go to ACTIVE.
- State ACTIVE:
  - sd_miso=tx_shift[7], MSB first. busy=1.
  - sck rising: rx_shift<={rx_shift[6:0],mosi}; bitcnt<=bitcnt+1 (3-bit wrap).
    - If bitcnt was 7: rx_data<={rx_shift[6:0],mosi}; rx_valid=1 for exactly one cycle.
  - sck falling:
    - If bitcnt==0 (byte boundary): reload tx_shift from the buffer or FILL_BYTE, as on entry.
    - Otherwise: tx_shift<={tx_shift[6:0],1'b1}.
  - ncs rising: return to IDLE.
    - A partial rx byte is discarded, with no rx_valid.
    - The tx shift contents are lost. An unconsumed buffer stays pending (tx_ready stays 0).
- Transmit buffer:
  - tx_load with tx_ready=1: capture tx_data, tx_ready<=0 next cycle.
  - tx_load with tx_ready=0: ignored; tx_overrun<=1. tx_overrun clears only on reset.
  - tx_load in the same cycle as a consuming reload: the reload takes the old buffer, then the new byte is accepted (tx_ready stays 0).
- A byte loaded after the falling edge that starts a byte is sent in the next byte slot.
- Simultaneous sck and ncs edges in one cycle: ncs has priority and the sck edge is ignored.
- Every sck edge while ncs is deasserted is ignored.

Optional Feature:
- Macro ZX_SPI_RESPONDER_ECHO_EN.
- Defined: when the buffer is empty at a byte boundary, the responder transmits the previously received rx_data instead of FILL_BYTE (loopback echo for link self-test). The first byte after ncs falling still uses FILL_BYTE.
- Undefined: the empty-buffer byte is always FILL_BYTE.

Test Plan:
- Reset, then ncs low and 8 SCK pulses with MOSI=0xA5, no tx_load -> one rx_valid, rx_data=0xA5, MISO bits read 0xFF.
- tx_load 0x3C while idle, then one byte transfer -> MISO reads 0x3C; tx_ready returns 1 at ncs falling. A second byte reads 0xFF.
- Two back-to-back bytes 0x01, 0x80, with 0x55 loaded during the first byte -> rx_valid twice, rx_data 0x01 then 0x80; second MISO byte=0x55.
- Deassert ncs after 5 SCK pulses -> no rx_valid. The next full byte 0xC3 is received correctly (bitcnt restarted).
- tx_load 0x11, then tx_load 0x22 before any transfer -> tx_overrun=1; the transferred byte is 0x11.
- With ZX_SPI_RESPONDER_ECHO_EN, send 0x5A then 0x00 -> the second MISO byte is 0x5A.
